sprite_renderer: RTL

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_renderer_pkg.sv | 31 +++
 rtl/sprite_renderer_square_scan.sv | 57 +++++
 rtl/sprite_renderer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprite_renderer_pkg.sv
// rtl/sprite_renderer_pkg.sv - shared screen, sprite and colour constants plus the renderer state type
package sprite_renderer_pkg;

    localparam logic [8:0] SCREEN_W    = 9'd160;
    localparam logic [7:0] SCREEN_H    = 8'd120;
    localparam logic [2:0] PLAYER_SIZE = 3'd3;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_PLAYER = 3'b111;
    localparam logic [2:0] COL_HIT    = 3'b100;
    localparam logic [2:0] COL_ENEMY  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_P,
        S_DRAW_P,
        S_ERASE_E,
        S_DRAW_E,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic       hit;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] es;
    } sprites_t;

endpackage

// File: rtl/sprite_renderer_square_scan.sv
// rtl/sprite_renderer_square_scan.sv - row-major scan of one square, one pixel per clock
module square_scan
    import sprite_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] size,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       in_bounds,
    output logic       last
);

    logic [2:0] off_x_q, off_x_d;
    logic [2:0] off_y_q, off_y_d;
    logic [2:0] size_m1;
    logic [8:0] full_x;
    logic [7:0] full_y;

    assign size_m1 = size - 3'd1;
    assign last    = (off_x_q == size_m1) && (off_y_q == size_m1);

    // Widened sums so a sprite near the right/bottom edge clips instead of wrapping to 0.
    assign full_x    = {1'b0, base_x} + {6'd0, off_x_q};
    assign full_y    = {1'b0, base_y} + {5'd0, off_y_q};
    assign in_bounds = (full_x < SCREEN_W) && (full_y < SCREEN_H);
    assign pix_x     = full_x[7:0];
    assign pix_y     = full_y[6:0];

    always_comb begin
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        if (start || last) begin
            off_x_d = 3'd0;
            off_y_d = 3'd0;
        end else if (off_x_q == size_m1) begin
            off_x_d = 3'd0;
            off_y_d = off_y_q + 3'd1;
        end else begin
            off_x_d = off_x_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_x_q <= 3'd0;
            off_y_q <= 3'd0;
        end else begin
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - player/enemy sprite renderer driving a VGA pixel-write port
// Define SPRITE_ERASE_EN to erase the previously drawn squares before redrawing.
module sprite_renderer
    import sprite_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic       player_hit,
    input  logic [7:0] enemy_x,
    input  logic [6:0] enemy_y,
    input  logic [2:0] enemy_size,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);

    state_e   state_q, state_d;
    sprites_t new_q, new_d;
    sprites_t old_view;
    logic     erase_old;

    logic       scan_start, scan_in_bounds, scan_last;
    logic [7:0] scan_base_x, scan_pix_x;
    logic [6:0] scan_base_y, scan_pix_y;
    logic [2:0] scan_size, col;

`ifdef SPRITE_ERASE_EN
    sprites_t old_q, old_d;
    logic     old_valid_q, old_valid_d;

    always_comb begin
        old_d       = old_q;
        old_valid_d = old_valid_q;
        if (state_q == S_DONE) begin
            old_d       = new_q;
            old_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_q       <= '0;
            old_valid_q <= 1'b0;
        end else begin
            old_q       <= old_d;
            old_valid_q <= old_valid_d;
        end
    end

    assign old_view  = old_q;
    assign erase_old = old_valid_q;
`else
    assign old_view  = '0;
    assign erase_old = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        new_d       = new_q;
        scan_base_x = 8'd0;
        scan_base_y = 7'd0;
        scan_size   = PLAYER_SIZE;
        col         = COL_BLACK;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    new_d   = '{player_x, player_y, player_hit, enemy_x, enemy_y, enemy_size};
                    state_d = erase_old ? S_ERASE_P : S_DRAW_P;
                end
            end
            S_ERASE_P: begin
                scan_base_x = old_view.px;
                scan_base_y = old_view.py;
                if (scan_last) state_d = S_DRAW_P;
            end
            S_DRAW_P: begin
                scan_base_x = new_q.px;
                scan_base_y = new_q.py;
                col         = new_q.hit ? COL_HIT : COL_PLAYER;
                if (scan_last) begin
                    if (erase_old && (old_view.es != 3'd0)) state_d = S_ERASE_E;
                    else if (new_q.es != 3'd0)              state_d = S_DRAW_E;
                    else                                    state_d = S_DONE;
                end
            end
            S_ERASE_E: begin
                scan_base_x = old_view.ex;
                scan_base_y = old_view.ey;
                scan_size   = old_view.es;
                if (scan_last) state_d = (new_q.es != 3'd0) ? S_DRAW_E : S_DONE;
            end
            S_DRAW_E: begin
                scan_base_x = new_q.ex;
                scan_base_y = new_q.ey;
                scan_size   = new_q.es;
                col         = COL_ENEMY;
                if (scan_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            new_q   <= '0;
        end else begin
            state_q <= state_d;
            new_q   <= new_d;
        end
    end

    // The scanner wraps to offset 0 on its own last pixel, so phases chain without a gap.
    assign scan_start = (state_q == S_IDLE) || (state_q == S_DONE);

    square_scan u_scan (
        .clk       (clk),
        .reset     (reset),
        .start     (scan_start),
        .base_x    (scan_base_x),
        .base_y    (scan_base_y),
        .size      (scan_size),
        .pix_x     (scan_pix_x),
        .pix_y     (scan_pix_y),
        .in_bounds (scan_in_bounds),
        .last      (scan_last)
    );

    assign busy   = !scan_start;
    assign done   = (state_q == S_DONE);
    assign plot   = busy && scan_in_bounds;
    assign vga_x  = busy ? scan_pix_x : 8'd0;
    assign vga_y  = busy ? scan_pix_y : 7'd0;
    assign colour = busy ? col : COL_BLACK;

endmodule
